branch_resolve: RTL

- EX-stage consumer of the fetch-stage branch prediction (PredictedF/PredictedPC).
- Carries each prediction alongside its instruction from F through D to E.
- Compares the prediction against the resolved outcome (BranchE, BrNPC) and raises a one-shot misprediction redirect toward the hazard unit and PC mux.
- Produces a qualified predictor-update strobe for the BTB write port.

---
 rtl/branch_resolve.sv | 111 +++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: carries the fetch-stage prediction down to E, compares it with the
// resolved outcome, and emits a one-shot redirect plus a BTB update strobe. Optional perf counters: BRANCH_PERF_CNT_EN.
module branch_resolve #(
  parameter int          ADDR_W    = 32,
  parameter logic [6:0]  BR_OPCODE = 7'b110_0011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PCF,
  input  logic              PredictedF,
  input  logic [ADDR_W-1:0] PredictedPC,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic [ADDR_W-1:0] PCE,
  input  logic [6:0]        OpE,
  input  logic              BranchE,
  input  logic [ADDR_W-1:0] BrNPC,
  output logic              MispredictE,
  output logic [ADDR_W-1:0] RedirectPC,
  output logic              UpdateE,
  output logic              UpdateTaken
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]       BrCnt,
  output logic [31:0]       MissCnt
`endif
);

  logic              r_pred_d, r_pred_e, r_done_e;
  logic [ADDR_W-1:0] r_pred_pc_d, r_pred_pc_e;
  logic              w_is_br, w_fire;
  logic [ADDR_W-1:0] w_pc_plus4;

  // PCF only travels alongside the prediction for trace alignment; it never enters the compare.
  logic w_unused_pcf;
  assign w_unused_pcf = ^PCF;

  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      r_pred_d    <= 1'b0;
      r_pred_pc_d <= '0;
    end else if (!StallD) begin
      r_pred_d    <= PredictedF;
      r_pred_pc_d <= PredictedPC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      r_pred_e    <= 1'b0;
      r_pred_pc_e <= '0;
    end else if (!StallE) begin
      r_pred_e    <= r_pred_d;
      r_pred_pc_e <= r_pred_pc_d;
    end
  end

  // Remembers that the stalled E instruction already reported, so it pulses only once.
  always_ff @(posedge clk) begin
    if (rst || FlushE || !StallE) r_done_e <= 1'b0;
    else if (w_fire)               r_done_e <= 1'b1;
  end

  assign w_is_br    = (OpE == BR_OPCODE);
  assign w_pc_plus4 = PCE + ADDR_W'(4);
  assign w_fire     = MispredictE | UpdateE;

  always_comb begin
    MispredictE = 1'b0;
    RedirectPC  = '0;
    UpdateE     = 1'b0;
    UpdateTaken = 1'b0;
    if (!r_done_e) begin
      if (w_is_br) begin
        UpdateE     = 1'b1;
        UpdateTaken = BranchE;
        if (r_pred_e && !BranchE) begin
          MispredictE = 1'b1;
          RedirectPC  = w_pc_plus4;
        end else if (BranchE && (!r_pred_e || (r_pred_pc_e != BrNPC))) begin
          MispredictE = 1'b1;
          RedirectPC  = BrNPC;
        end
      end else if (r_pred_e) begin
        // Stale or aliased BTB hit on a non-branch: fall through to the sequential PC.
        MispredictE = 1'b1;
        RedirectPC  = w_pc_plus4;
      end
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] r_br_cnt, r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (UpdateE)     r_br_cnt   <= r_br_cnt + 32'd1;
      if (MispredictE) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign BrCnt   = r_br_cnt;
  assign MissCnt = r_miss_cnt;
`endif

endmodule
